// File: rtl/jk_latch_pkg.sv
// jk_latch_pkg: JK action encoding shared by the latch bank
package jk_latch_pkg;
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_action_e;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flop with enable and async active-low clear
module jk_cell
  import jk_latch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);
  jk_action_e act;
  logic d;
  // decode {j,k} into the value q takes on an enabled edge
  always_comb begin
    act = jk_action_e'({j, k});
    d   = act == SET ? 1'b1 : act == CLR ? 1'b0 : act == TGL ? ~q : q;
  end
  // reset clears immediately; otherwise update only on enabled edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else if (enable) q <= d;
  end
  assign qn = ~q;
endmodule

// File: rtl/jk_latch.sv
// jk_latch: bank of WIDTH independent JK elements with shared enable
module jk_latch #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i]),
      .qn    (qn[i])
    );
  end
endmodule

// File: tb/tb_jk_latch.sv
// tb_jk_latch: directed checks of single-bit and 4-bit JK banks
module tb_jk_latch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic j = 1'b0, k = 1'b0;
  logic q, qn;
  logic [3:0] j4 = 4'b0, k4 = 4'b0;
  logic [3:0] q4, qn4;
  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jk_latch #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .j(j), .k(k), .q(q), .qn(qn)
  );
  jk_latch #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .j(j4), .k(k4), .q(q4), .qn(qn4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    cmp++;
    if (q !== 1'b0 || qn !== 1'b1) begin
      bad++;
      $display("FAIL reset: q=%b qn=%b required q=0 qn=1", q, qn);
    end
    cmp++;
    if (q4 !== 4'b0000 || qn4 !== 4'b1111) begin
      bad++;
      $display("FAIL reset4: q=%b qn=%b required q=0000 qn=1111", q4, qn4);
    end
  endtask

  task automatic test_disabled;
    tick();
    reset = 1'b1;
    enable = 1'b0;
    j = 1'b1;
    k = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      cmp++;
      if (q !== 1'b0) begin
        bad++;
        $display("FAIL disabled_set edge%0d: q=%b required 0", n, q);
      end
    end
    j = 1'b0;
    k = 1'b1;
    tick();
    cmp++;
    if (q !== 1'b0) begin
      bad++;
      $display("FAIL disabled_clr: q=%b required 0", q);
    end
  endtask

  task automatic test_jk_modes;
    logic [1:0] jk_v [3] = '{2'b01, 2'b10, 2'b00};
    logic       exp_v[3] = '{1'b0, 1'b1, 1'b1};
    enable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      {j, k} = jk_v[n];
      tick();
      cmp++;
      if (q !== exp_v[n] || qn !== ~exp_v[n]) begin
        bad++;
        $display("FAIL jk_mode jk=%b: q=%b qn=%b required q=%b", jk_v[n], q, qn, exp_v[n]);
      end
    end
  endtask

  task automatic test_toggle;
    logic exp_v[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    j = 1'b1;
    k = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      cmp++;
      if (q !== exp_v[n] || qn !== ~exp_v[n]) begin
        bad++;
        $display("FAIL toggle edge%0d: q=%b qn=%b required q=%b", n, q, qn, exp_v[n]);
      end
    end
  endtask

  task automatic test_reset_mid;
    #3 reset = 1'b0;
    #1;
    cmp++;
    if (q !== 1'b0 || qn !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: q=%b qn=%b required q=0 qn=1", q, qn);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      cmp++;
      if (q !== 1'b0 || qn !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold edge%0d: q=%b qn=%b required q=0 qn=1", n, q, qn);
      end
    end
  endtask

  task automatic test_width4;
    logic [3:0] exp_v[2] = '{4'b1010, 4'b1000};
    j = 1'b0;
    k = 1'b0;
    reset = 1'b1;
    enable = 1'b1;
    j4 = 4'b1010;
    k4 = 4'b0110;
    for (int n = 0; n < 2; n++) begin
      tick();
      cmp++;
      if (q4 !== exp_v[n] || qn4 !== ~exp_v[n]) begin
        bad++;
        $display("FAIL width4 edge%0d: q=%b qn=%b required q=%b", n, q4, qn4, exp_v[n]);
      end
    end
    cmp++;
    if (q !== 1'b0) begin
      bad++;
      $display("FAIL width4_isolation: q=%b required 0", q);
    end
  endtask

  initial begin
    test_reset();
    test_disabled();
    test_jk_modes();
    test_toggle();
    test_reset_mid();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
